// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, control bit positions and ID/EX bubble
package mips_pkg;

  // Opcodes understood by the decode stage
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // WB field bit positions
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // M field bit positions
  localparam int M_BRANCH    = 2;
  localparam int M_MEM_READ  = 1;
  localparam int M_MEM_WRITE = 0;

  // EX field bit positions
  localparam int EX_ALUOP_HI = 3;
  localparam int EX_ALUOP_LO = 2;
  localparam int EX_REG_DST  = 1;
  localparam int EX_ALU_SRC  = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  // A bubble carries no control and zeroed data
  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 32x32 register file with writeback read bypass
module decode_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  logic [31:0] regs [32];
  logic        wb_active;

  // Register 0 is never written, so it stays at its reset value
  assign wb_active = wb_reg_write && (wb_rd != 5'd0);

  // Writeback on the rising edge; reset wins over a concurrent write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_active) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Reads forward the in-flight writeback so decode sees it this cycle
  always_comb begin
    read_data1 = regs[rs];
    read_data2 = regs[rt];
    if (wb_active && (wb_rd == rs)) read_data1 = wb_data;
    if (wb_active && (wb_rd == rt)) read_data2 = wb_data;
    if (rs == 5'd0) read_data1 = '0;
    if (rt == 5'd0) read_data2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with load-use hazard and ID/EX register
module decode_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] if_id,
  input  logic        flush,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [1:0]  out_WB,
  output logic [2:0]  out_M,
  output logic [3:0]  out_EX,
  output logic [31:0] out_incremented_PC,
  output logic [31:0] out_regData1,
  output logic [31:0] out_regData2,
  output logic [31:0] out_sign_extended_offset,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        illegal_op
);

  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  ctrl_t       ctrl;
  logic        uses_rt;
  logic        stall;
  id_ex_t      id_ex;
  id_ex_t      next_id_ex;

  assign pc_plus4 = if_id[63:32];
  assign instr    = if_id[31:0];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];

  decode_regfile u_regfile (
    .clk          (clk),
    .reset        (reset),
    .rs           (rs),
    .rt           (rt),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .read_data1   (read_data1),
    .read_data2   (read_data2)
  );

  // Opcode to control-field decode; unknown opcodes flag illegal with no controls
  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.wb[WB_REG_WRITE] = 1'b1;
        ctrl.ex[EX_ALUOP_HI]  = 1'b1;
        ctrl.ex[EX_REG_DST]   = 1'b1;
        uses_rt               = 1'b1;
      end
      OP_LW: begin
        ctrl.wb[WB_REG_WRITE]  = 1'b1;
        ctrl.wb[WB_MEM_TO_REG] = 1'b1;
        ctrl.m[M_MEM_READ]     = 1'b1;
        ctrl.ex[EX_ALU_SRC]    = 1'b1;
      end
      OP_SW: begin
        ctrl.m[M_MEM_WRITE]  = 1'b1;
        ctrl.ex[EX_ALU_SRC]  = 1'b1;
        uses_rt              = 1'b1;
      end
      OP_BEQ: begin
        ctrl.m[M_BRANCH]     = 1'b1;
        ctrl.ex[EX_ALUOP_LO] = 1'b1;
        uses_rt              = 1'b1;
      end
      OP_ADDI: begin
        ctrl.wb[WB_REG_WRITE] = 1'b1;
        ctrl.ex[EX_ALU_SRC]   = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // A load in EX whose destination feeds this instruction forces one bubble;
  // the bubble clears MemRead, so the stall cannot repeat for the same pair
  assign stall = id_ex.ctrl.m[M_MEM_READ] && (id_ex.rt != 5'd0) &&
                 ((id_ex.rt == rs) || (uses_rt && (id_ex.rt == rt)));

  // A flush discards the slot anyway, so fetch must keep moving
  assign pc_write    = ~stall | flush;
  assign if_id_write = ~stall | flush;

  // Next ID/EX contents: bubble on stall or flush, otherwise the decoded slot
  always_comb begin
    next_id_ex = BUBBLE;
    if (!(stall || flush)) begin
      next_id_ex.ctrl      = ctrl;
      next_id_ex.pc        = pc_plus4;
      next_id_ex.reg_data1 = read_data1;
      next_id_ex.reg_data2 = read_data2;
      next_id_ex.imm       = {{16{instr[15]}}, instr[15:0]};
      next_id_ex.rt        = rt;
      next_id_ex.rd        = rd;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (reset) id_ex <= BUBBLE;
    else       id_ex <= next_id_ex;
  end

  assign out_WB                   = id_ex.ctrl.wb;
  assign out_M                    = id_ex.ctrl.m;
  assign out_EX                   = id_ex.ctrl.ex;
  assign illegal_op               = id_ex.ctrl.illegal;
  assign out_incremented_PC       = id_ex.pc;
  assign out_regData1             = id_ex.reg_data1;
  assign out_regData2             = id_ex.reg_data2;
  assign out_sign_extended_offset = id_ex.imm;
  assign out_rt                   = id_ex.rt;
  assign out_rd                   = id_ex.rd;

endmodule
